// File: rtl/elevator_trip_scheduler.sv
// elevator_trip_scheduler
// Single-car trip sequencer: captures (pickup, drop-off) requests on the rising
// edge of input_confirm, queues them in a small FIFO and runs each trip as
// move-to-pickup, door dwell, move-to-destination, door dwell.
// Optional build macro: ELEVATOR_ESTOP_EN adds an active-high estop input that
// freezes step/door counting and holds the car while asserted.
module elevator_trip_scheduler #(
  parameter  int unsigned NUM_FLOORS  = 9,
  parameter  int unsigned FIFO_DEPTH  = 4,
  parameter  int unsigned STEP_CYCLES = 25000000,
  parameter  int unsigned DOOR_CYCLES = 50000000,
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ELEVATOR_ESTOP_EN
  input  logic             estop,
`endif
  input  logic [4:0]       req_current,
  input  logic [4:0]       req_destination,
  input  logic             input_confirm,
  output logic [4:0]       car_floor,
  output logic             moving_up,
  output logic             moving_down,
  output logic             door_open,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             trip_done,
  output logic             req_drop,
  output logic             req_err
);

  localparam int unsigned FLOOR_W = 5;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned STEP_W  = $clog2(STEP_CYCLES);
  localparam int unsigned DOOR_W  = $clog2(DOOR_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_PICK,
    DOOR_PICK,
    MOVE_DEST,
    DOOR_DEST
  } state_t;

  typedef struct packed {
    logic [FLOOR_W-1:0] pick;
    logic [FLOOR_W-1:0] dest;
  } trip_t;

  state_t             state, state_d;
  logic               confirm_q;
  trip_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_d;
  logic [FLOOR_W-1:0] pick, dest, pick_d, dest_d, floor_d, target_c;
  logic [STEP_W-1:0]  step_cnt, step_d;
  logic [DOOR_W-1:0]  door_cnt, door_d;
  trip_t              head_c;
  logic               confirm_rise_c, floor_ok_c, fifo_full_c;
  logic               pop_c, push_c, err_c, drop_c, freeze_c;
  logic               done_d, moving_up_d, moving_down_d, door_open_d, busy_d;

`ifdef ELEVATOR_ESTOP_EN
  assign freeze_c = estop;
`else
  assign freeze_c = 1'b0;
`endif

  // Request capture and FIFO push/pop qualification
  assign confirm_rise_c = input_confirm & ~confirm_q;
  assign floor_ok_c     = (req_current != '0) && (req_current <= FLOOR_W'(NUM_FLOORS)) &&
                          (req_destination != '0) && (req_destination <= FLOOR_W'(NUM_FLOORS));
  assign fifo_full_c    = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign head_c         = fifo_mem[rd_ptr];
  assign pop_c          = (state == IDLE) && (fifo_count != '0) && !freeze_c;
  assign push_c         = confirm_rise_c && floor_ok_c && (!fifo_full_c || pop_c);
  assign err_c          = confirm_rise_c && !floor_ok_c;
  assign drop_c         = confirm_rise_c && floor_ok_c && fifo_full_c && !pop_c;

  // Queue occupancy after this cycle's push/pop
  always_comb begin
    count_d = fifo_count;
    if (push_c && !pop_c) begin
      count_d = fifo_count + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = fifo_count - CNT_W'(1);
    end
  end

  // FIFO storage; entries are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= trip_t'{pick: req_current, dest: req_destination};
    end
  end

  // Trip sequencing: next state, position and counters
  always_comb begin
    state_d  = state;
    pick_d   = pick;
    dest_d   = dest;
    floor_d  = car_floor;
    step_d   = step_cnt;
    door_d   = door_cnt;
    done_d   = 1'b0;
    target_c = (state == MOVE_DEST) ? dest : pick;
    case (state)
      IDLE: begin
        if (pop_c) begin
          pick_d  = head_c.pick;
          dest_d  = head_c.dest;
          step_d  = '0;
          state_d = MOVE_PICK;
        end
      end
      MOVE_PICK, MOVE_DEST: begin
        if (!freeze_c) begin
          if (car_floor == target_c) begin
            step_d  = '0;
            door_d  = '0;
            state_d = (state == MOVE_PICK) ? DOOR_PICK : DOOR_DEST;
          end else if (step_cnt == STEP_W'(STEP_CYCLES - 1)) begin
            step_d  = '0;
            floor_d = (target_c > car_floor) ? car_floor + FLOOR_W'(1)
                                             : car_floor - FLOOR_W'(1);
          end else begin
            step_d = step_cnt + STEP_W'(1);
          end
        end
      end
      DOOR_PICK, DOOR_DEST: begin
        if (!freeze_c) begin
          if (door_cnt == DOOR_W'(DOOR_CYCLES - 1)) begin
            door_d = '0;
            if ((state == DOOR_PICK) && (dest != pick)) begin
              state_d = MOVE_DEST;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            door_d = door_cnt + DOOR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Display outputs derived from the upcoming state so they register in step with it
  always_comb begin
    moving_up_d   = 1'b0;
    moving_down_d = 1'b0;
    door_open_d   = 1'b0;
    busy_d        = (state_d != IDLE) || (count_d != '0);
    if (state_d == MOVE_PICK) begin
      moving_up_d   = pick_d > floor_d;
      moving_down_d = pick_d < floor_d;
    end else if (state_d == MOVE_DEST) begin
      moving_up_d   = dest_d > floor_d;
      moving_down_d = dest_d < floor_d;
    end else if ((state_d == DOOR_PICK) || (state_d == DOOR_DEST)) begin
      door_open_d = 1'b1;
    end
    if (freeze_c) begin
      moving_up_d   = 1'b0;
      moving_down_d = 1'b0;
      if (step_d == '0) begin
        door_open_d = 1'b1;
      end
    end
  end

  // State, pointers, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      confirm_q   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      pick        <= FLOOR_W'(1);
      dest        <= FLOOR_W'(1);
      car_floor   <= FLOOR_W'(1);
      step_cnt    <= '0;
      door_cnt    <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
      busy        <= 1'b0;
      trip_done   <= 1'b0;
      req_drop    <= 1'b0;
      req_err     <= 1'b0;
    end else begin
      state       <= state_d;
      confirm_q   <= input_confirm;
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count  <= count_d;
      pick        <= pick_d;
      dest        <= dest_d;
      car_floor   <= floor_d;
      step_cnt    <= step_d;
      door_cnt    <= door_d;
      moving_up   <= moving_up_d;
      moving_down <= moving_down_d;
      door_open   <= door_open_d;
      busy        <= busy_d;
      trip_done   <= done_d;
      req_drop    <= drop_c;
      req_err     <= err_c;
    end
  end

endmodule

// File: tb/tb_elevator_trip_scheduler.sv
// tb_elevator_trip_scheduler
// Directed and randomized requests compared every cycle against a trip-schedule
// model: each trip is a list of timed segments computed from floor distances.
module tb_elevator_trip_scheduler;

  localparam int NF = 9;
  localparam int FD = 4;
  localparam int SC = 4;
  localparam int DC = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] req_current = '0;
  logic [4:0] req_destination = '0;
  logic       input_confirm = 1'b0;
  logic [4:0] car_floor;
  logic       moving_up, moving_down, door_open, busy, trip_done, req_drop, req_err;
  logic [2:0] fifo_count;
`ifdef ELEVATOR_ESTOP_EN
  logic       estop = 1'b0;
`endif

  elevator_trip_scheduler #(
    .NUM_FLOORS(NF), .FIFO_DEPTH(FD), .STEP_CYCLES(SC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop),
`endif
    .req_current(req_current),
    .req_destination(req_destination),
    .input_confirm(input_confirm),
    .car_floor(car_floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .busy(busy),
    .fifo_count(fifo_count),
    .trip_done(trip_done),
    .req_drop(req_drop),
    .req_err(req_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int p; int d; } trip_s;
  trip_s q[$];
  bit m_active;
  int m_e, m_c0, m_p, m_d, m_floor;
  bit m_prev_conf;
  bit e_done, e_err, e_drop;

  // observations of the DUT for end-of-scenario checks
  int n_done, n_drop, n_err, n_door, n_move, peak;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int sgn(input int x);
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  function automatic int trip_len();
    int l;
    l = iabs(m_p - m_c0) * SC + 1 + DC;
    if (m_d != m_p) l += iabs(m_d - m_p) * SC + 1 + DC;
    return l;
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 0; m_e = 0; m_floor = 1; m_prev_conf = 0;
    e_done = 0; e_err = 0; e_drop = 0;
  endtask

  // advance the model by one clock edge with the inputs present before it
  task automatic model_edge(input bit conf, input int cur, input int dst);
    bit rise;
    trip_s t;
    e_done = 0; e_err = 0; e_drop = 0;
    rise = conf && !m_prev_conf;
    m_prev_conf = conf;
    if (m_active) begin
      m_e++;
      if (m_e == trip_len()) begin
        m_active = 0;
        m_floor  = m_d;
        e_done   = 1;
      end
    end else if (q.size() != 0) begin
      t = q.pop_front();
      m_active = 1; m_e = 0; m_c0 = m_floor; m_p = t.p; m_d = t.d;
    end
    if (rise) begin
      if (cur < 1 || cur > NF || dst < 1 || dst > NF) e_err = 1;
      else if (q.size() == FD) e_drop = 1;
      else begin
        t.p = cur; t.d = dst;
        q.push_back(t);
      end
    end
  endtask

  // position/motion/door expected during the current cycle
  task automatic expect_pos(output int fl, output bit up, output bit dn, output bit door);
    int l1, e2, a1, a2;
    fl = m_floor; up = 0; dn = 0; door = 0;
    if (m_active) begin
      a1 = iabs(m_p - m_c0);
      l1 = a1 * SC + 1;
      if (m_e < l1) begin
        fl = m_c0 + sgn(m_p - m_c0) * (m_e / SC);
        up = (m_e < a1 * SC) && (m_p > m_c0);
        dn = (m_e < a1 * SC) && (m_p < m_c0);
      end else if (m_e < l1 + DC) begin
        fl = m_p; door = 1;
      end else begin
        e2 = m_e - l1 - DC;
        a2 = iabs(m_d - m_p);
        if (e2 < a2 * SC + 1) begin
          fl = m_p + sgn(m_d - m_p) * (e2 / SC);
          up = (e2 < a2 * SC) && (m_d > m_p);
          dn = (e2 < a2 * SC) && (m_d < m_p);
        end else begin
          fl = m_d; door = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    int ef;
    bit eu, ed, eo;
    expect_pos(ef, eu, ed, eo);
    chk("car_floor",   32'(car_floor),   ef);
    chk("moving_up",   32'(moving_up),   32'(eu));
    chk("moving_down", 32'(moving_down), 32'(ed));
    chk("door_open",   32'(door_open),   32'(eo));
    chk("busy",        32'(busy),        (m_active || q.size() != 0) ? 1 : 0);
    chk("fifo_count",  32'(fifo_count),  q.size());
    chk("trip_done",   32'(trip_done),   32'(e_done));
    chk("req_drop",    32'(req_drop),    32'(e_drop));
    chk("req_err",     32'(req_err),     32'(e_err));
    n_done += int'(trip_done);
    n_drop += int'(req_drop);
    n_err  += int'(req_err);
    n_door += int'(door_open);
    n_move += int'(moving_up | moving_down);
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  task automatic clear_obs();
    n_done = 0; n_drop = 0; n_err = 0; n_door = 0; n_move = 0; peak = 0;
  endtask

  // one clock: drive after negedge, model the edge, sample at the next negedge
  task automatic cyc(input bit conf, input int cur, input int dst);
    input_confirm   = conf;
    req_current     = 5'(cur);
    req_destination = 5'(dst);
    @(posedge clk);
    model_edge(conf, cur, dst);
    @(negedge clk);
    compare_all();
  endtask

  task automatic request(input int cur, input int dst);
    cyc(1, cur, dst);
    cyc(0, 0, 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_active || q.size() != 0) && n < budget) begin
      cyc(0, 0, 0);
      n++;
    end
    cyc(0, 0, 0);
    chk("drain_busy", 32'(busy), 0);
  endtask

  // asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    input_confirm = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_obs();
    do_reset();

    // (3,7): full trip with two dwells
    clear_obs();
    request(3, 7);
    drain(300);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_door_cyc", n_door, 2 * DC);

    // (1,1) at floor 1: single dwell, no motion
    do_reset();
    clear_obs();
    request(1, 1);
    drain(100);
    chk("t2_done_cnt", n_done, 1);
    chk("t2_door_cyc", n_door, DC);
    chk("t2_move_cyc", n_move, 0);

    // held confirm: one request only
    do_reset();
    clear_obs();
    for (int i = 0; i < 20; i++) cyc(1, 2, 5);
    cyc(0, 0, 0);
    drain(300);
    chk("t3_peak", peak, 1);
    chk("t3_done_cnt", n_done, 1);

    // five requests during a trip: fifth dropped, four run in order
    do_reset();
    clear_obs();
    request(1, 9);
    request(2, 3);
    request(5, 1);
    request(9, 9);
    request(4, 6);
    request(7, 2);
    chk("t4_fifo_full", 32'(fifo_count), FD);
    chk("t4_drop_cnt", n_drop, 1);
    drain(1500);
    chk("t4_done_cnt", n_done, 5);

    // out-of-range floors
    do_reset();
    clear_obs();
    request(0, 4);
    request(3, 10);
    chk("t5_err_cnt", n_err, 2);
    chk("t5_fifo", 32'(fifo_count), 0);

    // reset while heading to the destination at floor 5
    do_reset();
    clear_obs();
    request(2, 8);
    request(4, 4);
    begin
      int n = 0;
      int ef;
      bit eu, ed, eo;
      expect_pos(ef, eu, ed, eo);
      while (!(m_active && m_e > 11 && ef == 5) && n < 300) begin
        cyc(0, 0, 0);
        n++;
        expect_pos(ef, eu, ed, eo);
      end
    end
    chk("t6_pre_floor", 32'(car_floor), 5);
    do_reset();
    chk("t6_floor", 32'(car_floor), 1);
    chk("t6_fifo", 32'(fifo_count), 0);
    chk("t6_door", 32'(door_open), 0);

    // randomized requests, including invalid floors and FIFO overflow
    clear_obs();
    begin
      bit conf = 0;
      int cur = 1, dst = 1;
      for (int i = 0; i < 2500; i++) begin
        if (conf) conf = ($urandom_range(0, 1) == 1);
        else if ($urandom_range(0, 5) == 0) begin
          conf = 1;
          cur = int'($urandom_range(0, 10));
          dst = int'($urandom_range(0, 10));
        end
        cyc(conf, cur, dst);
      end
    end
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
